// File: rtl/gaussian_stream_filter.sv
// gaussian_stream_filter
//   Streaming separable-binomial Gaussian filter. Accepts one raster-ordered
//   frame of IMG_W x IMG_H pixels (CHANNELS samples of BITS each, LSB-first)
//   and emits the valid-region filtered pixels with frame-buffer write
//   addresses. A bypass mode, latched at start, passes every pixel through.
//   Fixed 2-cycle latency from pixel acceptance to out_valid.
// Ports:
//   clk, rst (sync, active-low)
//   start, bypass          frame start request / mode captured at start
//   in_valid, in_ready     input handshake, in_pixel raster-order sample
//   out_valid, out_pixel, out_addr   one-cycle qualified output
//   busy, done             frame in progress / end-of-frame pulse
module gaussian_stream_filter #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned CHANNELS = 1,
  parameter int unsigned IMG_W    = 31,
  parameter int unsigned IMG_H    = 31,
  parameter int unsigned KSIZE    = 7,
  parameter int unsigned ADDRLEN  = 21
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     bypass,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNELS*BITS-1:0] in_pixel,
  output logic                     out_valid,
  output logic [CHANNELS*BITS-1:0] out_pixel,
  output logic [ADDRLEN-1:0]       out_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned PW    = CHANNELS * BITS;
  localparam int unsigned VW    = BITS + KSIZE - 1;
  localparam int unsigned SW    = BITS + 2 * (KSIZE - 1);
  localparam int unsigned SW1   = SW + 1;
  localparam int unsigned SHIFT = 2 * (KSIZE - 1);
  localparam int unsigned HALF  = 1 << (2 * KSIZE - 3);
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic int unsigned binom(input int unsigned n, input int unsigned k);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  state_t              state;
  logic                mode;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [ADDRLEN-1:0]  addr_cnt;
  logic                accept, emit, v0, v1;

  // lb is one shift chain of (KSIZE-1) rows; lb[r][IMG_W-1] is the pixel
  // r+1 rows above the incoming one, same column.
  logic [PW-1:0]       lb [KSIZE-1][IMG_W];
  // win[c][j]: column age c (0 = newest), row age j (0 = current row).
  logic [PW-1:0]       win [KSIZE][KSIZE];
  logic [PW-1:0]       column [KSIZE];
  logic [PW-1:0]       pix0, pix1, rounded;
  logic [ADDRLEN-1:0]  addr0, addr1;
  logic [CHANNELS*SW-1:0] sum_next, sum1;

  assign accept   = in_valid && (state == S_RUN);
  assign emit     = accept && (mode || (row >= RW'(KSIZE - 1) && col >= CW'(KSIZE - 1)));
  assign in_ready = (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_comb begin
    column[0] = in_pixel;
    for (int unsigned j = 1; j < KSIZE; j++) column[j] = lb[j-1][IMG_W-1];
  end

  // Vertical weighted sums per window column, then horizontal weighted sum.
  always_comb begin
    logic [VW-1:0] vs;
    logic [SW-1:0] hs;
    sum_next = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
      hs = '0;
      for (int unsigned c = 0; c < KSIZE; c++) begin
        vs = '0;
        for (int unsigned j = 0; j < KSIZE; j++)
          vs += VW'(binom(KSIZE - 1, j)) * VW'(win[c][j][ch*BITS +: BITS]);
        hs += SW'(binom(KSIZE - 1, c)) * SW'(vs);
      end
      sum_next[ch*SW +: SW] = hs;
    end
  end

  // Round half up; one extra bit keeps the rounding add from wrapping.
  always_comb begin
    rounded = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++)
      rounded[ch*BITS +: BITS] = BITS'((SW1'(sum1[ch*SW +: SW]) + SW1'(HALF)) >> SHIFT);
  end

  // Datapath storage: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb[0][0] <= in_pixel;
      for (int unsigned r = 1; r < KSIZE - 1; r++) lb[r][0] <= lb[r-1][IMG_W-1];
      for (int unsigned r = 0; r < KSIZE - 1; r++)
        for (int unsigned c = 1; c < IMG_W; c++) lb[r][c] <= lb[r][c-1];
      for (int unsigned j = 0; j < KSIZE; j++) win[0][j] <= column[j];
      for (int unsigned c = 1; c < KSIZE; c++)
        for (int unsigned j = 0; j < KSIZE; j++) win[c][j] <= win[c-1][j];
      pix0  <= in_pixel;
      addr0 <= addr_cnt;
    end
    if (v0) begin
      sum1  <= sum_next;
      pix1  <= pix0;
      addr1 <= addr0;
    end
  end

  // Control, counters and output registers. Outputs are emitted in address
  // order in both modes, so a running count of emitted pixels is the address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      mode      <= 1'b0;
      row       <= '0;
      col       <= '0;
      addr_cnt  <= '0;
      v0        <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_addr  <= '0;
    end else begin
      v0        <= emit;
      v1        <= v0;
      out_valid <= v1;
      if (emit) addr_cnt <= addr_cnt + 1'b1;
      if (v1) begin
        out_pixel <= mode ? pix1 : rounded;
        out_addr  <= addr1;
      end
      if (accept) begin
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (start) begin
          state    <= S_RUN;
          mode     <= bypass;
          row      <= '0;
          col      <= '0;
          addr_cnt <= '0;
        end
        S_RUN: if (accept && row == RW'(IMG_H - 1) && col == CW'(IMG_W - 1)) state <= S_DRAIN;
        // Last emission is in stage 2 once both earlier stages are empty.
        S_DRAIN: if (!v0 && !v1) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gaussian_stream_filter.md
# gaussian_stream_filter

Streaming, parametrised Gaussian filter engine: the next generation of the Gaussian filter datapath. It accepts one frame of raster-ordered pixels and produces the valid-region output pixels with write addresses for the frame buffer. It also pulses `done` at frame end. It generalises the fixed 7x7, single-channel, 8-bit filter to any odd kernel size, pixel width, frame size and channel count, and adds a bypass mode and input flow control.

## Interface
- `BITS`, 8, bits per channel sample
- `CHANNELS`, 1, independent channels packed LSB-first in one pixel word
- `IMG_W`, 31, frame width in pixels
- `IMG_H`, 31, frame height in pixels
- `KSIZE`, 7, kernel size; odd, 3..7, with KSIZE <= IMG_W and KSIZE <= IMG_H
- `ADDRLEN`, 21, output address width
- `clk`  in  1  single clock; everything is on its rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle frame start request
- `bypass`  in  1  sampled at accepted `start`; 1 = pass-through mode for the whole frame
- `in_valid`  in  1  `in_pixel` is valid
- `in_ready`  out  1  block accepts a pixel this cycle
- `in_pixel`  in  CHANNELS*BITS  raster-order input pixel
- `out_valid`  out  1  `out_pixel` and `out_addr` are valid (one-cycle qualifier)
- `out_pixel`  out  CHANNELS*BITS  filtered pixel
- `out_addr`  out  ADDRLEN  frame-buffer write address
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after the last output of a frame

## Operation
- FSM states:
  - IDLE: `start` -> RUN; the `bypass` value is latched into the mode register and the row/column counters are cleared.
  - RUN: once all IMG_W*IMG_H pixels have been accepted -> DRAIN.
  - DRAIN: once the pipeline is empty -> DONE.
  - DONE: one cycle, `done`=1 -> IDLE.
- Handshake: a pixel is accepted when `in_valid && in_ready`. `in_ready` = 1 only in RUN. There is no output backpressure. `in_valid` outside RUN is ignored.
- `start` outside IDLE is ignored. `busy` = 1 in RUN, DRAIN and DONE.
- Counters: col counts 0..IMG_W-1; on wrap, row increments 0..IMG_H-1. Both advance only on an accepted pixel.
- Line buffers: KSIZE-1 rows of IMG_W pixels each. They shift on every accepted pixel in both modes.
- Window: a KSIZE x KSIZE window register of the newest columns.
- Filter mode: a pixel is emitted only for an accepted pixel at (row, col) with row >= KSIZE-1 and col >= KSIZE-1.
  - Centre pixel: (row-(KSIZE-1)/2, col-(KSIZE-1)/2).
  - `out_addr` = (row-KSIZE+1)*(IMG_W-KSIZE+1) + (col-KSIZE+1).
  - Frame output count: (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1).
- Bypass mode: every accepted pixel is emitted unchanged; `out_addr` = row*IMG_W+col.
- Kernel: separable binomial. The 1-D coefficient k_i = C(KSIZE-1, i).
  - KSIZE=3: 1 2 1
  - KSIZE=5: 1 4 6 4 1
  - KSIZE=7: 1 6 15 20 15 6 1
- Arithmetic, per channel and independently:
  - Vertical sum width: BITS+KSIZE-1.
  - Horizontal sum of vertical sums width: BITS+2*(KSIZE-1). It is unsigned and never overflows.
  - Result = (sum + 2^(2*KSIZE-3)) >> 2*(KSIZE-1), i.e. round-half-up.
  - The result always fits in BITS; no saturation is needed.
- Reset (`rst`=0 at a clock edge), including mid-frame:
  - FSM -> IDLE; counters, mode and pipeline valid bits are cleared.
  - Line-buffer contents are don't-care.
  - Any partial frame is discarded; `done` is not pulsed.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_pixel`=0, `out_addr`=0, `busy`=0, `done`=0.
- `in_ready` rises the cycle after `start` is accepted.
- Latency: fixed 2 cycles in both modes. A pixel accepted at edge N yields `out_valid`=1 in the cycle after edge N+2.
- Input gaps (`in_valid`=0) do not stall the pipeline stages already in flight. Outputs appear exactly 2 cycles after their triggering input.
- `in_ready` drops the cycle after the last pixel is accepted.
- `done` is asserted 1 cycle after the final `out_valid` cycle. `busy` falls together with `done`.
- A new `start` is accepted from the first IDLE cycle, i.e. the cycle after `done`.
- `start` and `rst`=0 in the same cycle: reset wins.

## Test plan
- Defaults (31x31, K=7, 1 ch), constant frame of 100 with continuous `in_valid` -> 625 outputs, all 100, `out_addr` 0..624 in order, then one `done` pulse.
- K=3, 8x8 frame, a single 255 at (4,4) and 0 elsewhere:
  - address of centre (4,4) -> 64
  - addresses of edge neighbours -> 32
  - addresses of diagonals -> 16
  - all other addresses -> 0
  - 36 outputs total
- `bypass`=1, 31x31 ramp frame (value = index mod 256) -> 961 outputs equal to the input, `out_addr` 0..960, each 2 cycles after acceptance.
- Random `in_valid` gaps, CHANNELS=3 (channel values 0, 128, 255 constant) -> outputs 0/128/255 per channel, 2-cycle latency for every output, count and addresses identical to the gap-free run.
- `rst`=0 in the middle of a frame, then `start` plus a full constant-50 frame -> no `done` for the aborted frame; the second frame gives 625 outputs of 50 and one `done`.
- `start` pulsed during RUN -> ignored; the frame completes normally with exactly one `done`.
